// File: rtl/fp_pkg.sv
// fp_pkg: shared widths, FSM states and status flag indices
// for the sequential floating-point adder/subtractor.
package fp_pkg;

    localparam int EXP_W_DEF = 6;
    localparam int MAN_W_DEF = 25;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        ADD   = 3'd2,
        NORM  = 3'd3,
        ROUND = 3'd4
    } state_e;

    localparam int ST_EXACT   = 0;
    localparam int ST_OVF     = 1;
    localparam int ST_UNF     = 2;
    localparam int ST_INEXACT = 3;

    function automatic int bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/fp_align_shifter.sv
// fp_align_shifter: combinational right shifter that also reports
// whether any set bit was shifted out (sticky).
module fp_align_shifter #(
    parameter int WIDTH = 29,
    parameter int SHW   = 6
) (
    input  logic [WIDTH-1:0] din,
    input  logic [SHW-1:0]   sh,
    output logic [WIDTH-1:0] dout,
    output logic             sticky
);

    logic [WIDTH-1:0] lost;

    assign dout   = din >> sh;
    assign lost   = din & ~({WIDTH{1'b1}} << sh);
    assign sticky = |lost;

endmodule

// File: rtl/fp_addsub_seq.sv
// fp_addsub_seq: multi-cycle FP add/sub with start/busy/done handshake.
// Build option FPADD_RNE_EN selects round-to-nearest-even, else truncate.
module fp_addsub_seq
    import fp_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         clock_100kHz,
    input  logic         reset,
    input  logic         start,
    input  logic         op_sub,
    input  logic [W-1:0] op_A_in,
    input  logic [W-1:0] op_B_in,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] data_out,
    output logic [3:0]   status_out
);

    localparam int SW = MAN_W + 4;
    localparam int XW = EXP_W + $clog2(SW) + 2;
    localparam logic [XW-1:0] EXP_TOP =
        {{(XW-EXP_W){1'b0}}, {EXP_W{1'b1}}};

    state_e           state;
    logic             sign_a;
    logic             sign_b;
    logic             res_sign;
    logic             bypass;
    logic [EXP_W-1:0] exp_a;
    logic [EXP_W-1:0] exp_b;
    logic [EXP_W-1:0] shamt;
    logic [MAN_W-1:0] man_a;
    logic [MAN_W-1:0] man_b;
    logic [SW-1:0]    sig_bs;
    logic [SW:0]      sum;
    logic [XW-1:0]    exp_r;

    logic             eff_b;
    logic             swap;
    logic [SW-1:0]    sig_a;
    logic [SW-1:0]    sig_b;
    logic [SW-1:0]    b_sh;
    logic             b_stk;
    logic [SW:0]      add_res;
    logic             inc;
    logic [MAN_W:0]   man_rnd;
    logic [XW-1:0]    exp_rnd;
    logic [W-1:0]     res_n;
    logic [3:0]       st_n;

    assign eff_b = op_B_in[W-1] ^ op_sub;
    assign swap  = op_B_in[W-2:0] > op_A_in[W-2:0];
    assign sig_a = {1'b1, man_a, 3'b000};
    assign sig_b = {1'b1, man_b, 3'b000};

    fp_align_shifter #(
        .WIDTH (SW),
        .SHW   (EXP_W)
    ) u_align (
        .din    (sig_b),
        .sh     (shamt),
        .dout   (b_sh),
        .sticky (b_stk)
    );

    assign add_res = (sign_a == sign_b)
                   ? {1'b0, sig_a} + {1'b0, sig_bs}
                   : {1'b0, sig_a} - {1'b0, sig_bs};

`ifdef FPADD_RNE_EN
    assign inc = sum[2] & (sum[1] | sum[0] | sum[3]);
`else
    assign inc = 1'b0;
`endif

    // a carry out of the mantissa wraps it to zero and bumps the exponent
    assign man_rnd = {1'b0, sum[SW-2:3]} + {{MAN_W{1'b0}}, inc};
    assign exp_rnd = exp_r + {{(XW-1){1'b0}}, man_rnd[MAN_W]};

    always_comb begin
        res_n = '0;
        st_n  = '0;
        if (bypass) begin
            res_n = {res_sign, exp_r[EXP_W-1:0], sum[SW-2:3]};
            st_n[ST_EXACT] = 1'b1;
        end else if (exp_r[XW-1] || exp_r == '0) begin
            res_n = {res_sign, {(W-1){1'b0}}};
            st_n[ST_UNF]     = 1'b1;
            st_n[ST_INEXACT] = 1'b1;
        end else if (exp_rnd >= EXP_TOP) begin
            res_n = {res_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            st_n[ST_OVF]     = 1'b1;
            st_n[ST_INEXACT] = 1'b1;
        end else begin
            res_n = {res_sign, exp_rnd[EXP_W-1:0], man_rnd[MAN_W-1:0]};
            st_n[ST_INEXACT] = |sum[2:0];
            st_n[ST_EXACT]   = ~|sum[2:0];
        end
    end

    always_ff @(posedge clock_100kHz or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            data_out   <= '0;
            status_out <= '0;
            sign_a     <= 1'b0;
            sign_b     <= 1'b0;
            res_sign   <= 1'b0;
            bypass     <= 1'b0;
            exp_a      <= '0;
            exp_b      <= '0;
            shamt      <= '0;
            man_a      <= '0;
            man_b      <= '0;
            sig_bs     <= '0;
            sum        <= '0;
            exp_r      <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        busy   <= 1'b1;
                        bypass <= 1'b0;
                        state  <= ALIGN;
                        if (swap) begin
                            sign_a <= eff_b;
                            exp_a  <= op_B_in[W-2:MAN_W];
                            man_a  <= op_B_in[MAN_W-1:0];
                            sign_b <= op_A_in[W-1];
                            exp_b  <= op_A_in[W-2:MAN_W];
                            man_b  <= op_A_in[MAN_W-1:0];
                            shamt  <= op_B_in[W-2:MAN_W]
                                    - op_A_in[W-2:MAN_W];
                        end else begin
                            sign_a <= op_A_in[W-1];
                            exp_a  <= op_A_in[W-2:MAN_W];
                            man_a  <= op_A_in[MAN_W-1:0];
                            sign_b <= eff_b;
                            exp_b  <= op_B_in[W-2:MAN_W];
                            man_b  <= op_B_in[MAN_W-1:0];
                            shamt  <= op_A_in[W-2:MAN_W]
                                    - op_B_in[W-2:MAN_W];
                        end
                    end
                end
                ALIGN: begin
                    exp_r    <= {{(XW-EXP_W){1'b0}}, exp_a};
                    res_sign <= sign_a;
                    sig_bs   <= b_sh | {{(SW-1){1'b0}}, b_stk};
                    // zero results travel the remaining stages untouched
                    if (exp_a == '0) begin
                        bypass   <= 1'b1;
                        res_sign <= sign_a & sign_b;
                        sum      <= '0;
                    end else if (exp_b == '0) begin
                        bypass <= 1'b1;
                        sum    <= {2'b01, man_a, 3'b000};
                    end
                    state <= ADD;
                end
                ADD: begin
                    if (!bypass) begin
                        sum <= add_res;
                        if (add_res == '0) begin
                            bypass   <= 1'b1;
                            res_sign <= 1'b0;
                            exp_r    <= '0;
                        end
                    end
                    state <= NORM;
                end
                NORM: begin
                    if (bypass) begin
                        state <= ROUND;
                    end else if (sum[SW]) begin
                        sum   <= {1'b0, sum[SW:2], sum[1] | sum[0]};
                        exp_r <= exp_r + 1'b1;
                    end else if (!sum[SW-1]) begin
                        sum   <= sum << 1;
                        exp_r <= exp_r - 1'b1;
                    end else begin
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    data_out   <= res_n;
                    status_out <= st_n;
                    done       <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_addsub_seq.sv
// tb_fp_addsub_seq: directed and random checks of fp_addsub_seq
// against an arithmetic reference model (default 6/25 format).
module tb_fp_addsub_seq;
    import fp_pkg::*;

    logic        clock_100kHz = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        op_sub = 1'b0;
    logic [31:0] op_A_in = '0;
    logic [31:0] op_B_in = '0;
    logic        busy;
    logic        done;
    logic [31:0] data_out;
    logic [3:0]  status_out;

    fp_addsub_seq dut (
        .clock_100kHz (clock_100kHz),
        .reset        (reset),
        .start        (start),
        .op_sub       (op_sub),
        .op_A_in      (op_A_in),
        .op_B_in      (op_B_in),
        .busy         (busy),
        .done         (done),
        .data_out     (data_out),
        .status_out   (status_out)
    );

    always #5 clock_100kHz = ~clock_100kHz;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  s;
        int          lat;
        int          t0;
    } exp_t;

    localparam longint HID = 64'd1 << 25;

`ifdef FPADD_RNE_EN
    localparam logic [31:0] RND_RES = 32'h3E000001;
`else
    localparam logic [31:0] RND_RES = 32'h3E000000;
`endif

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;
    logic [31:0] last_d = '0;
    logic [3:0]  last_s = '0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)",
                     name, act, req, $time);
        end
    endtask

    // Real-valued view: significands scaled by 8 to carry G/R/S.
    function automatic void model(input logic [31:0] a,
                                  input logic [31:0] b,
                                  input bit sub,
                                  output logic [31:0] r,
                                  output logic [3:0] st,
                                  output int lat);
        longint ea, eb, ma, mb, t, sa_v, sb_v, s, m, grs;
        bit     sa, sb, tsg, uf;
        int     n;
        ea = a[30:25]; ma = a[24:0]; sa = a[31];
        eb = b[30:25]; mb = b[24:0]; sb = b[31] ^ sub;
        if (eb * HID + mb > ea * HID + ma) begin
            t = ea; ea = eb; eb = t;
            t = ma; ma = mb; mb = t;
            tsg = sa; sa = sb; sb = tsg;
        end
        lat = 5;
        r = '0;
        st = 4'b0001;
        if (ea == 0) begin
            r = {sa & sb, 31'd0};
            return;
        end
        if (eb == 0) begin
            r = {sa, ea[5:0], ma[24:0]};
            return;
        end
        sa_v = (HID + ma) * 8;
        sb_v = (HID + mb) * 8;
        if (ea - eb >= 29)
            sb_v = 1;
        else if (ea - eb > 0)
            sb_v = (sb_v >> (ea - eb))
                 | longint'((sb_v % (64'd1 << (ea - eb))) != 0);
        s = (sa == sb) ? sa_v + sb_v : sa_v - sb_v;
        if (s == 0) begin
            r = '0;
            return;
        end
        n = 0;
        if (s >= 16 * HID) begin
            s = (s >> 1) | (s & 1);
            ea++;
            n++;
        end
        while (s < 8 * HID) begin
            s = s << 1;
            ea--;
            n++;
        end
        lat = 5 + n;
        uf = (ea <= 0);
        grs = s % 8;
        m = (s / 8) % HID;
`ifdef FPADD_RNE_EN
        if (grs > 4 || (grs == 4 && m % 2 == 1)) begin
            m++;
            if (m == HID) begin
                m = 0;
                ea++;
            end
        end
`endif
        if (uf) begin
            r = {sa, 31'd0};
            st = 4'b1100;
        end else if (ea >= 63) begin
            r = {sa, 6'h3F, 25'd0};
            st = 4'b1010;
        end else begin
            r = {sa, ea[5:0], m[24:0]};
            st = (grs != 0) ? 4'b1000 : 4'b0001;
        end
    endfunction

    // single compare process: samples 1 unit after each rising edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clock_100kHz);
            #1;
            cyc++;
            if (mon_en) begin
                if (done) begin
                    check("done_expected", q.size() != 0, 1);
                    if (q.size() != 0) begin
                        e = q.pop_front();
                        check("data", data_out, e.d);
                        check("status", status_out, e.s);
                        check("latency", cyc - e.t0, e.lat);
                        check("busy_at_done", busy, 0);
                        last_d = e.d;
                        last_s = e.s;
                    end
                end else begin
                    check("hold_data", data_out, last_d);
                    check("hold_status", status_out, last_s);
                    check("busy", busy, q.size() != 0);
                    if (q.size() != 0 && cyc - q[0].t0 > 100) begin
                        check("latency_bound", cyc - q[0].t0, q[0].lat);
                        q.delete();
                    end
                end
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input bit sub);
        exp_t e;
        @(negedge clock_100kHz);
        model(a, b, sub, e.d, e.s, e.lat);
        e.t0 = cyc;
        q.push_back(e);
        op_A_in = a;
        op_B_in = b;
        op_sub  = sub;
        start   = 1'b1;
        @(negedge clock_100kHz);
        start   = 1'b0;
        op_A_in = $urandom;
        op_B_in = $urandom;
        op_sub  = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            if (q.size() == 0) return;
            @(negedge clock_100kHz);
        end
        check("wait_idle_bound", q.size(), 0);
        q.delete();
    endtask

    task automatic directed(input string name,
                            input logic [31:0] a, input logic [31:0] b,
                            input bit sub, input logic [31:0] rd,
                            input logic [3:0] rs, input int rl);
        logic [31:0] md;
        logic [3:0]  ms;
        int          ml;
        model(a, b, sub, md, ms, ml);
        check({name, "_model_data"}, md, rd);
        check({name, "_model_status"}, ms, rs);
        check({name, "_model_latency"}, ml, rl);
        issue(a, b, sub);
        wait_idle();
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        bit          s;
        int          k;

        reset = 1'b0;
        repeat (2) @(negedge clock_100kHz);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_data", data_out, 0);
        check("rst_status", status_out, 0);
        reset  = 1'b1;
        mon_en = 1'b1;

        directed("one_plus_one", 32'h3E000000, 32'h3E000000, 1'b0,
                 32'h40000000, 4'b0001, 6);
        directed("one_minus_one", 32'h3E000000, 32'h3E000000, 1'b1,
                 32'h00000000, 4'b0001, 5);
        directed("1p5_plus_1", 32'h3F000000, 32'h3E000000, 1'b0,
                 32'h40800000, 4'b0001, 6);
        directed("overflow", 32'h7C000000, 32'h7C000000, 1'b0,
                 32'h7E000000, 4'b1010, 6);
        directed("round", 32'h3E000000, 32'h0B000000, 1'b0,
                 RND_RES, 4'b1000, 5);
        directed("zero_a", 32'h00000000, 32'hBE000000, 1'b0,
                 32'hBE000000, 4'b0001, 5);
        directed("neg_zeros", 32'h80000000, 32'h00000000, 1'b1,
                 32'h80000000, 4'b0001, 5);
        directed("underflow", 32'h03000000, 32'h02000000, 1'b1,
                 32'h00000000, 4'b1100, 6);
        directed("sub_shift", 32'h3E000000, 32'h3D000000, 1'b1,
                 32'h3A000000, 4'b0001, 7);

        // a second start while busy must not be taken
        issue(32'h3F000000, 32'h3E000000, 1'b0);
        @(negedge clock_100kHz);
        start   = 1'b1;
        op_A_in = 32'h7C000000;
        op_B_in = 32'h3D000000;
        @(negedge clock_100kHz);
        start = 1'b0;
        wait_idle();

        // reset while the carry renormalisation is in progress
        issue(32'h3E000000, 32'h3E000000, 1'b0);
        repeat (3) @(posedge clock_100kHz);
        @(negedge clock_100kHz);
        mon_en = 1'b0;
        q.delete();
        reset = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_data", data_out, 0);
        check("midrst_status", status_out, 0);
        last_d = '0;
        last_s = '0;
        @(negedge clock_100kHz);
        reset  = 1'b1;
        mon_en = 1'b1;
        directed("after_reset", 32'h3F000000, 32'h3E000000, 1'b0,
                 32'h40800000, 4'b0001, 6);

        for (int i = 0; i < 300; i++) begin
            a = $urandom;
            b = $urandom;
            s = 1'($urandom_range(0, 1));
            k = $urandom_range(0, 7);
            if (k == 0)
                b[30:25] = '0;
            else if (k == 1)
                a[30:25] = '0;
            else if (k < 4)
                b[30:25] = a[30:25] - 6'($urandom_range(0, 3));
            else if (k == 4) begin
                b[30:0] = a[30:0];
                b[0] = b[0] ^ 1'($urandom_range(0, 1));
            end else if (k == 5)
                a[30:25] = 6'(bias(6));
            issue(a, b, s);
            wait_idle();
        end

        repeat (3) @(negedge clock_100kHz);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_addsub_seq.md
# fp_addsub_seq

Parametrised, sequential floating-point adder/subtractor, the next generation of the team's 32-bit custom-format adder. It adds configurable exponent and mantissa widths, an add/subtract mode, a start/busy/done handshake, guard/round/sticky rounding, explicit zero handling and one-hot status flags. It sits on the 100 kHz datapath and is started by the control sequencer one operation at a time.

## Interface
- EXP_W, default 6: exponent field width; bias = 2^(EXP_W-1)-1.
- MAN_W, default 25: stored mantissa width; hidden 1 is implicit.
- Word width W = 1+EXP_W+MAN_W, 32 by default. Layout: sign [W-1], exponent [W-2:MAN_W], mantissa [MAN_W-1:0].
- clock_100kHz  input  1  clock.
- reset  input  1  asynchronous, active-low.
- start  input  1  request; sampled only in IDLE.
- op_sub  input  1  0 = A+B, 1 = A−B; captured with the operands.
- op_A_in  input  W  operand A.
- op_B_in  input  W  operand B.
- busy  output  1  high from the cycle after start acceptance until done.
- done  output  1  one-cycle pulse when a result is valid.
- data_out  output  W  result; held until the next done.
- status_out  output  4  one-hot-ish flags: [0] exact, [1] overflow, [2] underflow, [3] inexact.

## Operation
- Reset values: busy=0, done=0, data_out=0, status_out=0, FSM=IDLE.
- Encoding: an exponent field of 0 means zero, and the mantissa is ignored. An exponent of all-ones is the overflow/saturation code. There are no denormals.
- Effective B sign = sign_B XOR op_sub.
- IDLE: on start, register both operands swapped so that A holds the larger magnitude, compared on {exp,man}. Register shift amount = expA−expB. Go to ALIGN. A start while busy is ignored.
- ALIGN: significands are {1,man,G,R,S} with MAN_W+4 bits. Shift B right by the shift amount. Bits shifted out OR into S. A shift ≥ MAN_W+3 leaves B as S only.
- Zero operands are resolved here.
  - One operand zero: the result is the other operand with its effective sign, exact.
  - Both zero: −0 if both effective signs are negative, else +0.
  - Either case skips to ROUND with no rounding.
- ADD: equal effective signs give sum = A+B (MAN_W+5 bits); otherwise sum = A−B. Result sign = sign of A.
- Exact cancellation (sum=0) gives +0 with status exact. It goes directly to ROUND.
- NORM performs one action per cycle:
  - Carry bit set: shift right 1, with the shifted-out bit ORed into S, and exp+1.
  - Hidden bit clear: shift left 1 and exp−1.
  - Otherwise: go to ROUND.
- ROUND: apply the rounding mode from Configuration. A rounding carry-out renormalises in the same cycle (mantissa 0, exp+1).
- ROUND then checks limits and writes the result:
  - exp ≥ all-ones: data_out = {sign, all-ones, 0}, status = overflow|inexact.
  - exp ≤ 0 at any point: data_out = {sign, 0, 0}, status = underflow|inexact.
  - Otherwise: inexact if G|R|S was nonzero, else exact.
  - Write data_out and status_out, pulse done, go to IDLE.
- Exactly one of exact/inexact is always set.

## Timing
- Start is accepted at edge E0.
- E1 ALIGN, E2 ADD, E3 first NORM cycle, ROUND after NORM. done is high after edge E4 + n, where n = extra NORM shift cycles.
- Minimum latency is 5 cycles from start to done; zero and cancellation paths also take 5.
- Carry renormalisation adds 1 cycle. Maximum cancellation adds MAN_W+1 cycles.
- busy rises after E0 and falls with the done cycle. A new start is accepted in the cycle after done.
- Reset mid-operation aborts immediately to reset values; the partial result is discarded.

## Configuration
- FPADD_RNE_EN defined: round-to-nearest-even. Increment when G & (R|S|LSB).
- FPADD_RNE_EN undefined: truncate. G/R/S are discarded but still set inexact.

## Structure
- Package fp_pkg holds:
  - default EXP_W/MAN_W parameters;
  - state enum (IDLE, ALIGN, ADD, NORM, ROUND);
  - localparams for status bit indices;
  - a function for the bias.
- Sub-module fp_align_shifter: combinational right shifter with sticky collection, parametrised on width and shift width.

## Test plan
All cases use defaults (bias 31); 1.0 = 0x3E000000.
- 0x3E000000 + 0x3E000000 → 0x40000000, status exact, done 6 cycles after start (one carry shift).
- 0x3E000000 − 0x3E000000 (op_sub=1) → 0x00000000, exact, 5 cycles.
- 0x3F000000 (1.5) + 0x3E000000 → 0x40800000 (2.5), exact.
- 0x7C000000 + 0x7C000000 → 0x7E000000, overflow|inexact.
- 0x3E000000 + 0x0B000000 (1.5·2^-26) → 0x3E000001 with FPADD_RNE_EN, 0x3E000000 without; inexact in both builds.
- Start pulsed while busy is ignored; reset asserted at the NORM state → busy=0, done=0, data_out=0 immediately. The next start completes normally.
